// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead add/sub: one GROUP-bit lookahead group per stage, carry rippled stage to stage.
// Latency WIDTH/GROUP cycles, one beat per cycle; the whole pipe holds while the output beat is stalled.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_param_check
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end

  logic             adv;
  logic             out_vld_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             zero_q;

  assign adv       = !out_vld_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_vld_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  // Returns carries into bits 0..GROUP-1 plus the group carry-out, each as a flat lookahead term.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             ci);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      term   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (term & g[j]);
        term   = term & p[j];
      end
      c[i+1] = c[i+1] | (term & ci);
    end
    return c;
  endfunction

  for (genvar k = 0; k < NG; k++) begin : g_stage
    localparam int IW = WIDTH - k * GROUP;
    localparam int SW = (k + 1) * GROUP;

    logic [IW-1:0]    a_s;
    logic [IW-1:0]    b_s;
    logic             cin_s;
    logic             vld_s;
    logic [GROUP:0]   cy;
    logic [GROUP-1:0] grp;
    logic [SW-1:0]    s_d;

    if (k == 0) begin : g_entry
      assign a_s   = a;
      assign b_s   = sub ? ~b : b;
      assign cin_s = sub ? ~c_in : c_in;
      assign vld_s = in_valid;
      assign s_d   = grp;
    end else begin : g_link
      assign a_s   = g_stage[k-1].g_reg.a_q;
      assign b_s   = g_stage[k-1].g_reg.b_q;
      assign cin_s = g_stage[k-1].g_reg.c_q;
      assign vld_s = g_stage[k-1].g_reg.vld_q;
      assign s_d   = {grp, g_stage[k-1].g_reg.s_q};
    end

    assign cy  = cla_carries(a_s[GROUP-1:0], b_s[GROUP-1:0], cin_s);
    assign grp = a_s[GROUP-1:0] ^ b_s[GROUP-1:0] ^ cy[GROUP-1:0];

    if (k < NG - 1) begin : g_reg
      // Only the not-yet-summed upper operand bits travel forward.
      logic                  vld_q;
      logic [IW-GROUP-1:0]   a_q;
      logic [IW-GROUP-1:0]   b_q;
      logic [SW-1:0]         s_q;
      logic                  c_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          s_q   <= '0;
          c_q   <= 1'b0;
        end else if (adv) begin
          vld_q <= vld_s;
          a_q   <= a_s[IW-1:GROUP];
          b_q   <= b_s[IW-1:GROUP];
          s_q   <= s_d;
          c_q   <= cy[GROUP];
        end
      end
    end else begin : g_out
      always_ff @(posedge clk) begin
        if (reset) begin
          out_vld_q <= 1'b0;
          sum_q     <= '0;
          c_out_q   <= 1'b0;
          ovf_q     <= 1'b0;
          zero_q    <= 1'b0;
        end else if (adv) begin
          out_vld_q <= vld_s;
          if (vld_s) begin
            sum_q   <= s_d;
            c_out_q <= cy[GROUP];
            ovf_q   <= cy[GROUP] ^ cy[GROUP-1];
            zero_q  <= (s_d == '0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at WIDTH=32, GROUP=8 (four stages).
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        c_out;
  logic        overflow;
  logic        zero;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  res_t exp_q[$];

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32), .GROUP(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0b want %0b", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: wide unsigned for carry, wide signed for overflow.
  function automatic res_t ref_model(input logic [31:0] x, input logic [31:0] y,
                                     input logic ci, input logic sb);
    res_t           r;
    longint unsigned ux, uy, uc, t;
    longint         sx, sy, sc, sr;
    ux = {32'd0, x};
    uy = {32'd0, y};
    uc = {63'd0, ci};
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    sc = {63'd0, ci};
    if (!sb) begin
      t   = ux + uy + uc;
      r.s = t[31:0];
      r.c = t[32];
      sr  = sx + sy + sc;
    end else begin
      r.s = x - y - {31'd0, ci};
      r.c = (ux >= uy + uc);
      sr  = sx - sy - sc;
    end
    r.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.z = (r.s == 32'd0);
    return r;
  endfunction

  // Called #1 after a rising edge; sends one beat and checks its result and latency.
  task automatic send_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic ci, input logic sb, input logic [31:0] es,
                          input logic ec, input logic ev, input logic ez);
    int n;
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    c_in      = ci;
    sub       = sb;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk1 ({tag, "_valid"}, out_valid, 1'b1);
    chk32({tag, "_latency"}, n, 32'd4);
    chk32({tag, "_sum"}, sum, es);
    chk1 ({tag, "_cout"}, c_out, ec);
    chk1 ({tag, "_ovf"}, overflow, ev);
    chk1 ({tag, "_zero"}, zero, ez);
    @(posedge clk); #1;
    chk1 ({tag, "_single"}, out_valid, 1'b0);
  endtask

  // Random stream with optional downstream stall window; scoreboard checks order and values.
  task automatic stream(input int nbeats, input int st_start, input int st_len, input int exp_last);
    int          sent, rcvd, cyc, last;
    bit          have, stalled_prev;
    logic [31:0] ca, cb, held;
    logic        cc, cs;
    res_t        e;
    sent = 0; rcvd = 0; cyc = 0; last = -1;
    have = 1'b0; stalled_prev = 1'b0; held = '0;
    ca = '0; cb = '0; cc = 1'b0; cs = 1'b0;
    exp_q.delete();
    while (rcvd < nbeats && cyc < nbeats * 3 + 50) begin
      if (!have && sent < nbeats) begin
        ca   = $urandom;
        cb   = $urandom;
        cc   = ($urandom_range(0, 1) != 0);
        cs   = ($urandom_range(0, 1) != 0);
        have = 1'b1;
      end
      in_valid  = have;
      a         = ca;
      b         = cb;
      c_in      = cc;
      sub       = cs;
      out_ready = !(cyc >= st_start && cyc < st_start + st_len);
      #1;
      if (stalled_prev && out_valid) chk32("stall_hold_sum", sum, held);
      if (out_valid && !out_ready) begin
        chk1("stall_in_ready", in_ready, 1'b0);
        held = sum;
      end
      stalled_prev = out_valid && !out_ready;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(ca, cb, cc, cs));
        sent++;
        have = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk1("stream_extra_out", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk32("stream_sum", sum, e.s);
          chk1 ("stream_cout", c_out, e.c);
          chk1 ("stream_ovf", overflow, e.v);
          chk1 ("stream_zero", zero, e.z);
        end
        rcvd++;
        last = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk32("stream_count", rcvd, nbeats);
    if (exp_last >= 0) chk32("stream_last_cycle", last, exp_last);
    @(posedge clk); #1;
    chk1("stream_drained", out_valid, 1'b0);
  endtask

  initial begin
    int n_out;
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1 ("rst_out_valid", out_valid, 1'b0);
    chk32("rst_sum", sum, 32'd0);
    chk1 ("rst_cout", c_out, 1'b0);
    chk1 ("rst_ovf", overflow, 1'b0);
    chk1 ("rst_zero", zero, 1'b0);
    chk1 ("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;

    send_one("ripple_all",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_one("pos_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_one("sub_neg",     32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    send_one("sub_pos",     32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    send_one("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    send_one("cin_group",   32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    send_one("borrow_in",   32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    send_one("sub_equal",   32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // 100 back-to-back beats: result i appears in cycle i+4.
    stream(100, -100, 0, 103);
    // Stall downstream for 10 cycles once the pipe is full.
    stream(20, 8, 10, -1);

    // Three beats in flight, then reset with a fourth beat offered the same cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = 32'h100 + i;
      b        = 32'h1;
      c_in     = 1'b0;
      sub      = 1'b0;
      @(posedge clk); #1;
    end
    reset    = 1'b1;
    a        = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    chk1 ("flush_out_valid", out_valid, 1'b0);
    chk32("flush_sum", sum, 32'd0);
    n_out = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) n_out++;
    end
    chk32("flush_no_stale", n_out, 32'd0);

    send_one("post_reset", 32'h0000_1234, 32'h0000_0F00, 1'b0, 1'b0, 32'h0000_2134, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
